csr_trap_unit: RTL
==================

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath and CSR width.
REQ-002 Parameter NUM_IRQ, default 4, external interrupt lines (1..16), mapped to mip/mie bits 16+i.
REQ-003 Parameter MTVEC_RESET, default 0, mtvec reset value.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 csr_addr  in  12  CSR address for read and write.
REQ-007 csr_op  in  2  00 none, 01 write, 10 set (OR), 11 clear (AND-NOT).
REQ-008 csr_wdata  in  XLEN  CSR write operand.
REQ-009 csr_rdata  out  XLEN  combinational read of csr_addr.
REQ-010 instr_valid  in  1  instruction at pc_i retires this cycle.
REQ-011 pc_i  in  XLEN  PC of the current instruction.
REQ-012 ecall_i  in  1  current instruction is ECALL.
REQ-013 mret_i  in  1  current instruction is MRET.
REQ-014 irq_i  in  NUM_IRQ  level-sensitive external interrupt requests.
REQ-015 trap_taken  out  1  redirect fetch to trap_pc this cycle.
REQ-016 trap_pc  out  XLEN  trap or MRET target.
REQ-017 stall  out  1  high in TRAP state; core retires nothing.

Function
REQ-018 CSR map: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle 0xB00; unmapped address reads 0, writes ignored.
REQ-019 CSR writes commit at the next rising edge, only when instr_valid=1 and state RUN; mepc bits[1:0] forced 0.
REQ-020 mcycle increments by 1 every cycle, wraps 2^XLEN-1 -> 0; a write that cycle loads the written value instead of incrementing.
REQ-021 mip[16+i] registers irq_i[i] every cycle (one-cycle latency); other mip bits read 0.
REQ-022 FSM states RUN, TRAP; RUN -> TRAP on any trap entry; TRAP -> RUN unconditionally after one cycle; MRET does not enter TRAP.
REQ-023 Exception: ecall_i=1 with instr_valid=1 in RUN -> trap entry with mcause=11.
REQ-024 Interrupt: mstatus.MIE=1 and (mip & mie)!=0, instr_valid=1, RUN -> trap entry; lowest index wins; mcause = {1'b1, 16+i}.
REQ-025 Priority: ECALL over interrupt over MRET over CSR write; a losing MRET or CSR write is discarded entirely.
REQ-026 Trap entry, same cycle: trap_taken=1 combinationally; at edge mepc<=pc_i, mcause set, MPIE<=MIE, MIE<=0.
REQ-027 trap_pc on trap: mtvec[1:0]=00 -> {mtvec[XLEN-1:2],2'b00}; 01 -> base + 4*cause for interrupts, base for exceptions; 1x treated as 00.
REQ-028 MRET in RUN with instr_valid=1 and no trap: trap_taken=1, trap_pc=mepc, at edge MIE<=MPIE, MPIE<=1.
REQ-029 In TRAP: stall=1, trap_taken=0, no trap entry, no CSR write, mcycle still counts, mip still samples.
REQ-030 trap_taken=0 and trap_pc=0 whenever no trap or MRET is active.

Reset
REQ-031 rst low asynchronously forces: state RUN, mstatus/mie/mepc/mcause/mip/mcycle = 0, mtvec = MTVEC_RESET; outputs trap_taken=0, stall=0, trap_pc=0.
REQ-032 rst asserted in TRAP returns to RUN; pending irq_i re-sampled one cycle after release.

Verification
REQ-033 Write mtvec=0x100 (op01), read 0x305 -> 0x100; set 0x300 with 0x8 -> mstatus=0x8; clear with 0x8 -> 0.
REQ-034 MIE=1, mie=0x30000, irq_i=4'b0011, pc_i=0x40 -> trap_taken 2nd cycle, trap_pc=0x100, mepc=0x40, mcause=0x80000010, MIE=0, MPIE=1, stall next cycle.
REQ-035 mtvec=0x101, irq_i[1] only enabled -> trap_pc=0x100+4*17=0x144.
REQ-036 ecall_i and pending enabled irq same cycle, pc_i=0x80 -> mcause=11, mepc=0x80, trap_pc=mtvec base.
REQ-037 mret_i after trap -> trap_pc=mepc, MIE=1, MPIE=1; mret_i with CSR write same cycle and ecall_i -> write discarded.
REQ-038 mcycle written 0xFFFFFFFF, next cycle 0; rst low mid-TRAP -> stall=0, all CSRs reset immediately.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with ECALL/interrupt trap entry and MRET return.
// A trap entry spends one cycle in TRAP, stalling the core while fetch is redirected.
`timescale 1ns/1ps
module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic               instr_valid,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               ecall_i,
  input  logic               mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_taken,
  output logic [XLEN-1:0]    trap_pc,
  output logic               stall
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] TRAP = 1'b1;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;

  logic [0:0]         state;
  logic               status_mie;
  logic               status_mpie;
  logic [XLEN-1:0]    mie_r;
  logic [XLEN-1:0]    mtvec;
  logic [XLEN-1:0]    mepc;
  logic [XLEN-1:0]    mcause;
  logic [NUM_IRQ-1:0] mip_irq;
  logic [XLEN-1:0]    mcycle;

  logic               active;
  logic [NUM_IRQ-1:0] irq_en;
  logic               irq_hit;
  logic [4:0]         irq_idx;
  logic [XLEN-1:0]    cause_num;
  logic [XLEN-1:0]    vec_base;
  logic               take_ecall;
  logic               take_irq;
  logic               trap_entry;
  logic               do_mret;
  logic               do_write;
  logic [XLEN-1:0]    mip_val;
  logic [XLEN-1:0]    status_val;
  logic [XLEN-1:0]    wr_val;

  assign active   = rst && instr_valid && (state == RUN);
  assign irq_en   = mip_irq & mie_r[16 +: NUM_IRQ] & {NUM_IRQ{status_mie}};
  assign vec_base = {mtvec[XLEN-1:2], 2'b00};

  // Scan downward so the lowest pending index is the one left standing.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_en[i]) begin
        irq_hit = 1'b1;
        irq_idx = 5'(i);
      end
    end
  end

  assign cause_num  = XLEN'(irq_idx) + XLEN'(16);
  assign take_ecall = active && ecall_i;
  assign take_irq   = active && !ecall_i && irq_hit;
  assign trap_entry = take_ecall || take_irq;
  assign do_mret    = active && !trap_entry && mret_i;
  assign do_write   = active && !trap_entry && !do_mret && (csr_op != 2'b00);

  always_comb begin
    mip_val = '0;
    mip_val[16 +: NUM_IRQ] = mip_irq;
    status_val = '0;
    status_val[3] = status_mie;
    status_val[7] = status_mpie;
  end

  always_comb begin
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = status_val;
      ADDR_MIE:     csr_rdata = mie_r;
      ADDR_MTVEC:   csr_rdata = mtvec;
      ADDR_MEPC:    csr_rdata = mepc;
      ADDR_MCAUSE:  csr_rdata = mcause;
      ADDR_MIP:     csr_rdata = mip_val;
      ADDR_MCYCLE:  csr_rdata = mcycle;
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   wr_val = csr_wdata;
      2'b10:   wr_val = csr_rdata | csr_wdata;
      2'b11:   wr_val = csr_rdata & ~csr_wdata;
      default: wr_val = csr_rdata;
    endcase
  end

  // Vectored mode (mtvec[1:0]==01) offsets only interrupts; mode 1x behaves as direct.
  always_comb begin
    trap_taken = trap_entry || do_mret;
    trap_pc    = '0;
    if (take_irq && mtvec[1:0] == 2'b01)
      trap_pc = vec_base + (cause_num << 2);
    else if (trap_entry)
      trap_pc = vec_base;
    else if (do_mret)
      trap_pc = mepc;
  end

  assign stall = rst && (state == TRAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_r       <= '0;
      mtvec       <= MTVEC_RESET;
      mepc        <= '0;
      mcause      <= '0;
    end else begin
      if (state == TRAP)
        state <= RUN;
      else if (trap_entry)
        state <= TRAP;

      if (trap_entry) begin
        mepc        <= pc_i & ~XLEN'(3);
        mcause      <= take_ecall ? XLEN'(11) : ({1'b1, {(XLEN-1){1'b0}}} | cause_num);
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (do_mret) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end else if (do_write) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            status_mie  <= wr_val[3];
            status_mpie <= wr_val[7];
          end
          ADDR_MIE:    mie_r  <= wr_val;
          ADDR_MTVEC:  mtvec  <= wr_val;
          ADDR_MEPC:   mepc   <= wr_val & ~XLEN'(3);
          ADDR_MCAUSE: mcause <= wr_val;
          default: ;
        endcase
      end
    end
  end

  // The cycle counter and interrupt sampling keep running through TRAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle  <= '0;
      mip_irq <= '0;
    end else begin
      mip_irq <= irq_i;
      if (do_write && csr_addr == ADDR_MCYCLE)
        mcycle <= wr_val;
      else
        mcycle <= mcycle + XLEN'(1);
    end
  end

endmodule
